// File: rtl/fb_bra_resolve_unit_pkg.sv
// Shared types and constants for the execute-stage branch resolution unit:
// JALR FSM state encoding, one-hot branch-type bit positions, NZCV bundle.
package fb_bra_resolve_unit_pkg;

  localparam int FB_W       = 32;
  localparam int BRA_CTRL_W = 6;

  // One-hot branch-type vector is {beq,bne,blt,bge,bltu,bgeu}, beq in the MSB.
  localparam int BRA_BEQ  = 5;
  localparam int BRA_BNE  = 4;
  localparam int BRA_BLT  = 3;
  localparam int BRA_BGE  = 2;
  localparam int BRA_BLTU = 1;
  localparam int BRA_BGEU = 0;

  // JALR release FSM.
  typedef enum logic [1:0] {
    JALR_IDLE = 2'd0,
    JALR_WAIT = 2'd1,
    JALR_FIRE = 2'd2
  } jalr_state_e;

  // Condition flags of rs1 - rs2.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/fb_bra_flag_gen.sv
// Combinational rs1 - rs2 subtractor producing NZCV; shared with the ALU flag path.
// Carry is NOT-borrow: c = 1 iff rs1 >= rs2 unsigned.
module fb_bra_flag_gen
  import fb_bra_resolve_unit_pkg::*;
(
  input  logic [FB_W-1:0] rs1_i,
  input  logic [FB_W-1:0] rs2_i,
  output nzcv_t           flags_o
);

  logic [FB_W:0] diff;

  // Two's-complement subtract as rs1 + ~rs2 + 1 so the carry-out is NOT-borrow.
  assign diff = {1'b0, rs1_i} + {1'b0, ~rs2_i} + {{FB_W{1'b0}}, 1'b1};

  assign flags_o.n = diff[FB_W-1];
  assign flags_o.z = (diff[FB_W-1:0] == '0);
  assign flags_o.c = diff[FB_W];
  assign flags_o.v = (rs1_i[FB_W-1] != rs2_i[FB_W-1]) &
                     (diff[FB_W-1] != rs1_i[FB_W-1]);

endmodule

// File: rtl/fb_bra_resolve_unit.sv
// Execute-stage branch resolution: registers the EX/MEM branch record with its
// NZCV flags, runs the JALR release FSM (one-cycle jalr_en plus operands), and
// keeps resolved-branch / mispredict performance counters.
module fb_bra_resolve_unit
  import fb_bra_resolve_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_branch,
  input  logic [FB_W-1:0]       ex_pc,
  input  logic [FB_W-1:0]       ex_imm,
  input  logic [BRA_CTRL_W-1:0] ex_bra_control,
  input  logic [FB_W-1:0]       ex_rs1,
  input  logic [FB_W-1:0]       ex_rs2,
  input  logic                  lock,
  input  logic                  jalr_rs1_busy,
  input  logic [FB_W-1:0]       id_rs1_data,
  input  logic [FB_W-1:0]       id_jalr_imm,
  output logic                  branch,
  output logic [FB_W-1:0]       bra_pc,
  output logic [FB_W-1:0]       bra_imm,
  output logic [BRA_CTRL_W-1:0] bra_control,
  output logic                  NF,
  output logic                  ZF,
  output logic                  CF,
  output logic                  VF,
  output logic                  jalr_en,
  output logic [FB_W-1:0]       rs1_data,
  output logic [FB_W-1:0]       jalr_imm,
  output logic [CNT_W-1:0]      br_cnt,
  output logic [CNT_W-1:0]      mis_cnt
);

  nzcv_t                 ex_flags;
  nzcv_t                 flags_q;
  logic                  branch_q;
  logic [FB_W-1:0]       bra_pc_q;
  logic [FB_W-1:0]       bra_imm_q;
  logic [BRA_CTRL_W-1:0] bra_control_q;

  jalr_state_e           state_q, state_d;
  logic                  post_fire_q;
  logic                  capture;
  logic                  jalr_en_d;
  logic [FB_W-1:0]       rs1_data_q;
  logic [FB_W-1:0]       jalr_imm_q;

  logic [CNT_W-1:0]      br_cnt_q;
  logic [CNT_W-1:0]      mis_cnt_q;

  fb_bra_flag_gen u_flag_gen (
    .rs1_i   (ex_rs1),
    .rs2_i   (ex_rs2),
    .flags_o (ex_flags)
  );

  // EX/MEM record: flush clears (and drops any same-cycle new branch), stall holds.
  always_ff @(posedge clk) begin
    // NOTE: state is written with <= so every register samples pre-edge values;
    // a blocking = here would let later statements see the freshly updated value.
    if (rst || flush) begin
      branch_q      <= 1'b0;
      bra_pc_q      <= '0;
      bra_imm_q     <= '0;
      bra_control_q <= '0;
      flags_q       <= '0;
    end else if (!stall) begin
      branch_q      <= ex_branch;
      bra_pc_q      <= ex_pc;
      bra_imm_q     <= ex_imm;
      bra_control_q <= ex_bra_control;
      flags_q       <= ex_flags;
    end
  end

  // Performance counters: only advance on non-stalled cycles, wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (!stall) begin
      if (branch_q)         br_cnt_q  <= br_cnt_q + CNT_W'(1);
      if (flush && branch_q) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end

  // JALR FSM state register; post_fire_q masks the still-high lock after FIRE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= JALR_IDLE;
      post_fire_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      post_fire_q <= (state_q == JALR_FIRE);
    end
  end

  // JALR FSM next-state and outputs; FIRE always exits after one cycle, even under stall.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d   = state_q;
    capture   = 1'b0;
    jalr_en_d = 1'b0;
    unique case (state_q)
      JALR_IDLE: begin
        if (lock && !stall && !post_fire_q) state_d = JALR_WAIT;
      end
      JALR_WAIT: begin
        if (flush) begin
          state_d = JALR_IDLE;
        end else if (!stall && !jalr_rs1_busy) begin
          state_d = JALR_FIRE;
          capture = 1'b1;
        end
      end
      JALR_FIRE: begin
        state_d   = JALR_IDLE;
        jalr_en_d = !flush;
      end
      default: state_d = JALR_IDLE;
    endcase
  end

  // JALR operands: captured on the WAIT->FIRE transition, cleared by flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rs1_data_q <= '0;
      jalr_imm_q <= '0;
    end else if (capture) begin
      rs1_data_q <= id_rs1_data;
      jalr_imm_q <= id_jalr_imm;
    end
  end

  assign branch      = branch_q;
  assign bra_pc      = bra_pc_q;
  assign bra_imm     = bra_imm_q;
  assign bra_control = bra_control_q;
  assign NF          = flags_q.n;
  assign ZF          = flags_q.z;
  assign CF          = flags_q.c;
  assign VF          = flags_q.v;
  assign jalr_en     = jalr_en_d;
  assign rs1_data    = rs1_data_q;
  assign jalr_imm    = jalr_imm_q;
  assign br_cnt      = br_cnt_q;
  assign mis_cnt     = mis_cnt_q;

endmodule
